timeout_arbiter: RTL and testbench

Shares a single timeout counter among N requesters, one timed window at a time. Each requester asks for the timer and is granted exclusive use in round-robin order. The window ends when the holder releases it or the counter reaches the programmed limit, in which case an expiry pulse tagged with the holder's ID is raised. The block sits between the game/control FSMs and the timeout counter, so one counter serves every turn or phase timer in the design.

---
 rtl/timer_pkg.sv | 13 +
 rtl/timeout_counter.sv | 29 ++
 rtl/timeout_arbiter.sv | 97 +++++++++
 tb/tb_timeout_arbiter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared types and constants for the timeout arbiter slice.
package timer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEFAULT_TIMEOUT = 20;
  // Ten seconds at a 50 MHz clock; still fits in the 30-bit counter.
  localparam int PROD_TIMEOUT    = 500_000_000;

endpackage

// File: rtl/timeout_counter.sv
// Saturating window counter.
// Cleared synchronously, counts up while enabled, and holds at LIMIT.
module timeout_counter #(
  parameter int CW    = 30,
  parameter int LIMIT = 20
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          at_limit
);

  localparam logic [CW-1:0] LIM = CW'(LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en && (count != LIM)) begin
      count <= count + 1'b1;
    end
  end

  assign at_limit = (count == LIM);

endmodule

// File: rtl/timeout_arbiter.sv
// Round-robin owner of one shared timeout counter.
// The end-of-window strobe is the port rel, because release is a reserved word.
module timeout_arbiter
  import timer_pkg::*;
#(
  parameter int N       = 4,
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int CW      = 30
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         rel,
  output logic [N-1:0]         grant,
  output logic                 busy,
  output logic [CW-1:0]        count,
  output logic                 expired,
  output logic [$clog2(N)-1:0] expired_id
);

  localparam int IW = $clog2(N);

  state_t        state;
  logic [IW-1:0] last_winner;
  logic [IW:0]   pick;
  logic [N-1:0]  pick_onehot;
  logic          at_limit;
  logic          holder_rel;
  logic          window_end;

  // The lowest offset from last+1 wins, so the loop runs downward and the last write wins.
  function automatic logic [IW:0] rr_pick(input logic [N-1:0] r, input logic [IW-1:0] last);
    logic [IW:0] res;
    res = '0;
    for (int i = N; i >= 1; i--) begin
      int k;
      k = (int'(last) + i) % N;
      if (r[IW'(k)]) res = {1'b1, IW'(k)};
    end
    return res;
  endfunction

  always_comb begin
    pick        = rr_pick(req, last_winner);
    pick_onehot = '0;
    pick_onehot[pick[IW-1:0]] = 1'b1;
  end

  // last_winner doubles as the holder index while a window is running.
  assign holder_rel = (state == RUN) && rel[last_winner];
  assign window_end = (state == RUN) && (holder_rel || at_limit);
  assign expired    = (state == RUN) && at_limit && !holder_rel;
  assign expired_id = expired ? last_winner : '0;
  assign busy       = (state == RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      grant       <= '0;
      last_winner <= IW'(N - 1);
    end else begin
      case (state)
        IDLE: begin
          if (pick[IW]) begin
            state       <= RUN;
            grant       <= pick_onehot;
            last_winner <= pick[IW-1:0];
          end
        end
        RUN: begin
          if (window_end) begin
            state <= IDLE;
            grant <= '0;
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
        end
      endcase
    end
  end

  // Clearing on the final cycle makes the following idle cycle read zero.
  timeout_counter #(
    .CW    (CW),
    .LIMIT (TIMEOUT)
  ) u_counter (
    .clk      (clk),
    .rst      (rst),
    .clear    ((state == IDLE) || window_end),
    .en       (state == RUN),
    .count    (count),
    .at_limit (at_limit)
  );

endmodule

// File: tb/tb_timeout_arbiter.sv
// Scoreboard bench for timeout_arbiter against a behavioural owner/elapsed model.
module tb_timeout_arbiter;

  localparam int N       = 4;
  localparam int TIMEOUT = 20;
  localparam int CW      = 30;
  localparam int IW      = $clog2(N);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req = '0;
  logic [N-1:0]  rel = '0;
  logic [N-1:0]  grant;
  logic          busy;
  logic [CW-1:0] count;
  logic          expired;
  logic [IW-1:0] expired_id;

  typedef struct {
    logic [N-1:0] grant;
    logic         busy;
    int           count;
    logic         expired;
    int           expid;
  } exp_t;

  exp_t expq[$];
  int   assert_count = 0;
  int   fail_count   = 0;

  // Model: current owner (-1 when idle), cycles elapsed in the window, last owner served.
  int m_holder = -1;
  int m_cnt    = 0;
  int m_last   = N - 1;

  timeout_arbiter #(.N(N), .TIMEOUT(TIMEOUT), .CW(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .rel        (rel),
    .grant      (grant),
    .busy       (busy),
    .count      (count),
    .expired    (expired),
    .expired_id (expired_id)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete (actual running, required finished)");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assert_count++;
    if (act !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] bit_of(input int idx);
    logic [N-1:0] b;
    b = '0;
    if (idx >= 0) b[idx] = 1'b1;
    return b;
  endfunction

  // Computes this cycle's expected outputs, queues them, then advances the model one cycle.
  task automatic modelStep(input logic [N-1:0] r, input logic [N-1:0] rl);
    exp_t e;
    bit   owner_rel;
    owner_rel = (m_holder >= 0) && rl[m_holder];
    e.grant   = bit_of(m_holder);
    e.busy    = (m_holder >= 0);
    e.count   = (m_holder >= 0) ? m_cnt : 0;
    e.expired = (m_holder >= 0) && (m_cnt == TIMEOUT) && !owner_rel;
    e.expid   = e.expired ? m_holder : 0;
    expq.push_back(e);
    if (m_holder < 0) begin
      for (int i = 1; i <= N; i++) begin
        int k;
        k = (m_last + i) % N;
        if (r[k] && m_holder < 0) m_holder = k;
      end
      if (m_holder >= 0) begin
        m_last = m_holder;
        m_cnt  = 0;
      end
    end else if (owner_rel || m_cnt == TIMEOUT) begin
      m_holder = -1;
      m_cnt    = 0;
    end else begin
      m_cnt = m_cnt + 1;
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] r, input logic [N-1:0] rl);
    @(posedge clk);
    #1;
    req = r;
    rel = rl;
    modelStep(r, rl);
  endtask

  // Asserts reset partway through a cycle and checks that the outputs clear immediately.
  task automatic applyReset();
    @(posedge clk);
    #1;
    req = '0;
    rel = '0;
    rst = 1'b1;
    #1;
    checkOutput("rst_grant", 32'(grant), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_expired", 32'(expired), 32'd0);
    checkOutput("rst_expired_id", 32'(expired_id), 32'd0);
    m_holder = -1;
    m_cnt    = 0;
    m_last   = N - 1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        checkOutput("grant", 32'(grant), 32'(e.grant));
        checkOutput("busy", 32'(busy), 32'(e.busy));
        checkOutput("count", 32'(count), 32'(e.count));
        checkOutput("expired", 32'(expired), 32'(e.expired));
        checkOutput("expired_id", 32'(expired_id), 32'(e.expid));
      end
    end
  end

  initial begin : stimulus
    int guard;
    logic [N-1:0] r;
    logic [N-1:0] rl;

    applyReset();

    // Lone requester: full timeout, expiry, then re-grant after one idle cycle.
    for (int i = 0; i < 50; i++) applyStimulus(4'b0001, '0);
    guard = 0;
    while (m_holder >= 0 && guard < 40) begin
      applyStimulus('0, '0);
      guard++;
    end
    applyStimulus('0, '0);

    // Holder releases at count 5.
    for (int i = 0; i < 20; i++)
      applyStimulus(4'b0010, (m_holder == 1 && m_cnt == 5) ? 4'b0010 : 4'b0000);

    // Everyone requests; each holder gives up at count 2.
    for (int i = 0; i < 25; i++)
      applyStimulus(4'b1111, (m_holder >= 0 && m_cnt == 2) ? bit_of(m_holder) : 4'b0000);

    // Release coincides with the timeout cycle.
    for (int i = 0; i < 50; i++)
      applyStimulus(4'b0100, (m_holder >= 0 && m_cnt == TIMEOUT) ? bit_of(m_holder) : 4'b0000);

    // Foreign release and a dropped request from holder 0 are both ignored.
    guard = 0;
    while (!(m_holder == 0 && m_cnt == 0) && guard < 60) begin
      applyStimulus(4'b0001, '0);
      guard++;
    end
    checkOutput("reach_holder0", 32'(m_holder), 32'd0);
    for (int i = 0; i < 25; i++)
      applyStimulus('0, (m_cnt >= 5 && m_cnt <= 8) ? 4'b0100 : 4'b0000);

    // Reset in mid-window, then requesters 2 and 3 compete from a fresh pointer.
    guard = 0;
    while (!(m_holder == 0 && m_cnt == 10) && guard < 60) begin
      applyStimulus(4'b0001, '0);
      guard++;
    end
    checkOutput("reach_count10", 32'(m_cnt), 32'd10);
    applyReset();
    for (int i = 0; i < 6; i++) applyStimulus(4'b1100, '0);

    // Random traffic, with releases aimed mostly at the holder.
    for (int i = 0; i < 2000; i++) begin
      r  = N'($urandom);
      rl = '0;
      case ($urandom_range(0, 9))
        0: rl = N'($urandom);
        1, 2: rl = bit_of(m_holder);
        default: rl = '0;
      endcase
      applyStimulus(r, rl);
    end

    applyStimulus('0, '0);
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
